// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: control-unit opcodes, fetch FSM states
// and the canonical NOP encoding.
package riscv_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-outstanding imem fetch, redirect squash.
// Optional misaligned-target fault with `define FETCH_ALIGN_CHECK_EN.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_fault
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic            drop;
    logic [XLEN-1:0] target;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    logic fault;

    // Keep the raw target; low bits decide whether we fault.
    assign target      = redirect_pc;
    assign misaligned  = redirect & (redirect_pc[1:0] != 2'b00);
    assign fetch_fault = fault;
`else
    // Low bits are simply cleared, so fetches stay word aligned.
    assign target      = redirect_pc & ~XLEN'(3);
    assign fetch_fault = 1'b0;
`endif

    // Request is held off during reset even though state resets to S_REQ.
    assign imem_req_valid = (state == S_REQ) & ~reset;
    assign imem_req_addr  = pc;

    // Fetch FSM; redirect outranks every other event in a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault      <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_REQ: begin
                    if (redirect) begin
                        pc <= target;
                        if (imem_req_ready) begin
                            state <= S_WAIT;
                            drop  <= 1'b1;
                        end
                    end else if (imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        pc <= target;
                        if (imem_rsp_valid) begin
                            state <= S_REQ;
                            drop  <= 1'b0;
                        end else begin
                            drop  <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            inst       <= imem_rsp_data;
                            inst_pc    <= pc;
                            pc         <= pc + PC_STEP;
                            inst_valid <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc         <= target;
                        inst_valid <= 1'b0;
                        state      <= S_REQ;
                    end else if (inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
            endcase
`ifdef FETCH_ALIGN_CHECK_EN
            // A bad target parks the unit until reset; late responses are ignored.
            if (state != S_FAULT && misaligned) begin
                state      <= S_FAULT;
                inst_valid <= 1'b0;
                drop       <= 1'b0;
                fault      <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_fault;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: next fetch address, one outstanding fetch, one held inst.
    logic [31:0] m_pc    = '0;
    bit          m_out   = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_held  = 1'b0;
    bit          m_fault = 1'b0;
    logic [31:0] m_oaddr = '0;
    logic [31:0] m_hpc   = '0;
    logic [31:0] m_hdata = '0;
    int          m_wait  = 0;
    int          lat_fixed = 1;
    bit          mem_nop   = 1'b1;

    logic [31:0] acc_log[$];
    logic [31:0] xfer_pc_log[$];
    logic [31:0] xfer_data_log[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (mem_nop) return INST_NOP;
        return (a ^ 32'h5A5A_0013) + {a[7:0], 24'h0};
    endfunction

    function automatic int newlat();
        if (lat_fixed != 0) return lat_fixed;
        return int'($urandom_range(1, 3));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    task automatic compare();
        bit erv;
        erv = !m_fault && !m_out && !m_held;
        chk("req_valid", 32'(imem_req_valid), 32'(erv));
        if (erv) chk("req_addr", imem_req_addr, m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(m_held));
        if (m_held) begin
            chk("inst", inst, m_hdata);
            chk("inst_pc", inst_pc, m_hpc);
        end
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    endtask

    task automatic cycle(input bit rd, input logic [31:0] tgt,
                         input bit rr, input bit ir, input bit spur);
        bit          erv;
        bit          acc;
        bit          fire;
        logic [31:0] d;
        @(negedge clk);
        compare();
        erv  = !m_fault && !m_out && !m_held;
        fire = m_out && (m_wait <= 1);
        d    = fire ? memf(m_oaddr) : 32'hDEAD_BEEF;
        if (m_out && !fire) m_wait--;
        redirect       = rd;
        redirect_pc    = tgt;
        imem_req_ready = rr;
        inst_ready     = ir;
        imem_rsp_valid = fire || spur;
        imem_rsp_data  = d;
        acc = erv && rr;
        if (acc) acc_log.push_back(m_pc);
        if (m_held && ir) begin
            xfer_pc_log.push_back(m_hpc);
            xfer_data_log.push_back(m_hdata);
        end
        if (!m_fault) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (rd && tgt[1:0] != 2'b00) begin
                m_fault = 1'b1;
                m_held  = 1'b0;
                m_out   = 1'b0;
            end else
`endif
            if (rd) begin
                if (acc) begin
                    m_out = 1'b1; m_stale = 1'b1;
                    m_oaddr = m_pc; m_wait = newlat();
                end else if (fire) begin
                    m_out = 1'b0; m_stale = 1'b0;
                end else if (m_out) begin
                    m_stale = 1'b1;
                end
                m_held = 1'b0;
                m_pc   = tgt & ~32'h3;
            end else begin
                if (m_held && ir) m_held = 1'b0;
                if (acc) begin
                    m_out = 1'b1; m_stale = 1'b0;
                    m_oaddr = m_pc; m_wait = newlat();
                end else if (fire) begin
                    m_out = 1'b0;
                    if (!m_stale) begin
                        m_held  = 1'b1;
                        m_hpc   = m_oaddr;
                        m_hdata = d;
                        m_pc    = m_pc + 32'd4;
                    end
                    m_stale = 1'b0;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        redirect = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; inst_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        #1;
        chk("rst req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst req_addr", imem_req_addr, 32'h0);
        chk("rst inst_valid", 32'(inst_valid), 32'd0);
        chk("rst inst", inst, 32'h0);
        chk("rst inst_pc", inst_pc, 32'h0);
        chk("rst fault", 32'(fetch_fault), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_pc = '0; m_out = 1'b0; m_stale = 1'b0;
        m_held = 1'b0; m_fault = 1'b0; m_wait = 0;
    endtask

    initial begin
        logic [31:0] t;
        // Reset release, 1-cycle NOP memory, hold then stream.
        lat_fixed = 1; mem_nop = 1'b1;
        do_reset();
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 0, 0, 0);
        #1;
        chk("t1 lat inst_valid", 32'(inst_valid), 32'd1);
        chk("t1 lat inst", inst, 32'h0000_0013);
        chk("t1 lat inst_pc", inst_pc, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, '0, 1, 0, 0);
            #1;
            chk("t2 hold valid", 32'(inst_valid), 32'd1);
            chk("t2 hold pc", inst_pc, 32'h0);
            chk("t2 hold no req", 32'(imem_req_valid), 32'd0);
        end
        cycle(0, '0, 1, 1, 0);
        #1;
        chk("t2 one xfer", 32'(xfer_pc_log.size()), 32'd1);
        chk("t2 drop valid", 32'(inst_valid), 32'd0);
        chk("t2 next addr", imem_req_addr, 32'h4);
        for (int i = 0; i < 9; i++) cycle(0, '0, 1, 1, 0);
        chk("t1 acc0", acc_log[0], 32'h0);
        chk("t1 acc1", acc_log[1], 32'h4);
        chk("t1 acc2", acc_log[2], 32'h8);
        chk("t1 xpc0", xfer_pc_log[0], 32'h0);
        chk("t1 xpc1", xfer_pc_log[1], 32'h4);
        chk("t1 xpc2", xfer_pc_log[2], 32'h8);
        chk("t1 xdata", xfer_data_log[1], 32'h0000_0013);

        // Redirect while waiting; late response must be dropped.
        do_reset();
        mem_nop = 1'b0; lat_fixed = 3;
        cycle(0, '0, 1, 0, 0);
        cycle(1, 32'h100, 0, 0, 0);
        cycle(0, '0, 0, 0, 0);
        cycle(0, '0, 0, 0, 0);
        #1;
        chk("t3 dropped", 32'(inst_valid), 32'd0);
        chk("t3 req_valid", 32'(imem_req_valid), 32'd1);
        chk("t3 addr", imem_req_addr, 32'h100);
        lat_fixed = 1;
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 0, 0, 0);
        #1;
        chk("t3 inst_pc", inst_pc, 32'h100);
        chk("t3 inst", inst, 32'h5A5A_0113);

        // PC wrap at the top of the address space.
        cycle(1, 32'hFFFF_FFFC, 0, 0, 0);
        #1;
        chk("t4 addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("t4 killed", 32'(inst_valid), 32'd0);
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 0, 0, 0);
        #1;
        chk("t4 inst_pc", inst_pc, 32'hFFFF_FFFC);
        cycle(0, '0, 0, 1, 0);
        #1;
        chk("t4 wrap addr", imem_req_addr, 32'h0);

        // Reset mid-fetch, stray response after release.
        lat_fixed = 3;
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 0, 0, 0);
        do_reset();
        cycle(0, '0, 0, 0, 1);
        #1;
        chk("t5 ignored", 32'(inst_valid), 32'd0);
        chk("t5 addr", imem_req_addr, 32'h0);
        cycle(0, '0, 0, 0, 0);
        #1;
        chk("t5 still idle", 32'(inst_valid), 32'd0);
        lat_fixed = 1;
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 0, 0, 0);
        #1;
        chk("t5 fresh valid", 32'(inst_valid), 32'd1);
        chk("t5 fresh pc", inst_pc, 32'h0);

        // Misaligned redirect target.
        cycle(1, 32'h102, 0, 0, 0);
        #1;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t6 fault", 32'(fetch_fault), 32'd1);
        chk("t6 no req", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, 1, 0);
        #1;
        chk("t6 sticky", 32'(imem_req_valid), 32'd0);
`else
        chk("t6 aligned addr", imem_req_addr, 32'h100);
        chk("t6 req_valid", 32'(imem_req_valid), 32'd1);
        chk("t6 no fault", 32'(fetch_fault), 32'd0);
`endif

        // Random traffic against the model.
        do_reset();
        lat_fixed = 0;
        xfer_pc_log.delete();
        for (int i = 0; i < 4000; i++) begin
            t = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
            t = t & ~32'h3;
`endif
            cycle($urandom_range(0, 9) == 0, t,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, 0);
        end
        @(negedge clk);
        compare();
        chk("rand progress", 32'(xfer_pc_log.size() > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
